// File: rtl/snake_pkg.sv
// Shared definitions for the highscore table logic: table geometry and the
// read-out FSM state encoding.
package snake_pkg;

    localparam int SCORE_W    = 8;
    localparam int NUM_SCORES = 5;
    localparam int BCD_DIGITS = 3;
    localparam int IDX_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        PRESENT,
        FIN
    } state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 (double-dabble) binary to BCD converter. One shift per
// step cycle; cnt_done flags the cycle in which the final shift is taken.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BIN_W-1:0] din,
    input  logic             step,
    output logic [3:0]       hund,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic             cnt_done
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    logic [BIN_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_adj;
    logic [CNT_W-1:0] cnt_q;

    // Add-3 correction is applied to the digits before they are shifted.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            bin_q <= din;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (step && cnt_q != CNT_W'(BIN_W)) begin
            bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
            bin_q <= {bin_q[BIN_W-2:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_done = (cnt_q == CNT_W'(BIN_W - 1));
    assign hund     = bcd_q[8 +: 4];
    assign tens     = bcd_q[4 +: 4];
    assign ones     = bcd_q[0 +: 4];

endmodule

// File: rtl/highscore_reader.sv
// Highscore table read-out engine: snapshots the table on start and streams
// each entry as rank + BCD digits. HS_SKIP_ZERO_EN skips empty (zero) slots.
module highscore_reader #(
    parameter int NUM_SCORES = snake_pkg::NUM_SCORES,
    parameter int SCORE_W    = snake_pkg::SCORE_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_SCORES*SCORE_W-1:0] hi_scores,
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2:0]                    out_rank,
    output logic [3:0]                    out_hund,
    output logic [3:0]                    out_tens,
    output logic [3:0]                    out_ones,
    output logic                          out_last,
    output logic                          done
);

    import snake_pkg::*;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SCORE_W-1:0] snap_q [NUM_SCORES];

    logic               capture;
    logic               conv_load;
    logic               conv_step;
    logic [SCORE_W-1:0] conv_din;
    logic               conv_done;
    logic [3:0]         hund, tens, ones;
    logic               is_last;
    logic [IDX_W-1:0]   next_idx;

`ifdef HS_SKIP_ZERO_EN
    logic               any_nz;
    logic [IDX_W-1:0]   first_nz;
`endif

    bin2bcd_seq #(
        .BIN_W  (SCORE_W),
        .DIGITS (BCD_DIGITS)
    ) u_conv (
        .clk      (clk),
        .reset    (reset),
        .load     (conv_load),
        .din      (conv_din),
        .step     (conv_step),
        .hund     (hund),
        .tens     (tens),
        .ones     (ones),
        .cnt_done (conv_done)
    );

    always_comb begin
        next_idx = idx_q + 1'b1;
        is_last  = (idx_q == IDX_W'(NUM_SCORES - 1));
`ifdef HS_SKIP_ZERO_EN
        // Downward scans leave the nearest nonzero slot as the winner.
        any_nz   = 1'b0;
        first_nz = '0;
        is_last  = 1'b1;
        for (int j = NUM_SCORES - 1; j >= 0; j--) begin
            if (hi_scores[j*SCORE_W +: SCORE_W] != '0) begin
                any_nz   = 1'b1;
                first_nz = IDX_W'(j);
            end
            if (IDX_W'(j) > idx_q && snap_q[j] != '0) begin
                is_last  = 1'b0;
                next_idx = IDX_W'(j);
            end
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        capture   = 1'b0;
        conv_load = 1'b0;
        conv_step = 1'b0;
        conv_din  = snap_q[next_idx];
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
`ifdef HS_SKIP_ZERO_EN
                    if (any_nz) begin
                        idx_d     = first_nz;
                        conv_load = 1'b1;
                        conv_din  = hi_scores[first_nz*SCORE_W +: SCORE_W];
                        state_d   = CONV;
                    end else begin
                        idx_d   = '0;
                        state_d = FIN;
                    end
`else
                    idx_d     = '0;
                    conv_load = 1'b1;
                    conv_din  = hi_scores[SCORE_W-1:0];
                    state_d   = CONV;
`endif
                end
            end
            CONV: begin
                conv_step = 1'b1;
                if (conv_done) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    if (is_last) begin
                        state_d = FIN;
                    end else begin
                        idx_d     = next_idx;
                        conv_load = 1'b1;
                        state_d   = CONV;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int k = 0; k < NUM_SCORES; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (capture) begin
                for (int k = 0; k < NUM_SCORES; k++) begin
                    snap_q[k] <= hi_scores[k*SCORE_W +: SCORE_W];
                end
            end
        end
    end

    // Beat fields are forced to zero outside PRESENT so idle outputs read 0.
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign out_valid = (state_q == PRESENT);
    assign out_rank  = out_valid ? (idx_q + 3'd1) : 3'd0;
    assign out_hund  = out_valid ? hund : 4'd0;
    assign out_tens  = out_valid ? tens : 4'd0;
    assign out_ones  = out_valid ? ones : 4'd0;
    assign out_last  = out_valid & is_last;

endmodule

// File: tb/tb_highscore_reader.sv
// Directed self-checking bench for highscore_reader (default build, all
// entries emitted).
module tb_highscore_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [39:0] hi_scores;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_rank;
    logic [3:0]  out_hund, out_tens, out_ones;
    logic        out_last;
    logic        done;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    highscore_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .hi_scores (hi_scores),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rank  (out_rank),
        .out_hund  (out_hund),
        .out_tens  (out_tens),
        .out_ones  (out_ones),
        .out_last  (out_last),
        .done      (done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [39:0] pack(input int r1, input int r2, input int r3, input int r4, input int r5);
        logic [39:0] t;
        t = {r5[7:0], r4[7:0], r3[7:0], r2[7:0], r1[7:0]};
        return t;
    endfunction

    // Loads the table and pulses start; returns at the negedge after the capture edge.
    task automatic applyStimulus(input logic [39:0] tbl);
        @(negedge clk);
        hi_scores = tbl;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitValid(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < 40) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        if (!ok) checkOutput("valid timeout", 0, 1);
    endtask

    task automatic checkBeat(input int rank, input int h, input int t, input int o, input int last);
        string p;
        p = $sformatf("rank%0d", rank);
        checkOutput({p, " rank"}, 32'(out_rank), rank);
        checkOutput({p, " hund"}, 32'(out_hund), h);
        checkOutput({p, " tens"}, 32'(out_tens), t);
        checkOutput({p, " ones"}, 32'(out_ones), o);
        checkOutput({p, " last"}, 32'(out_last), last);
    endtask

    // Waits for a beat with out_ready low, optionally holds it, then accepts it.
    task automatic takeBeat(input int rank, input int h, input int t, input int o, input int last, input int hold);
        int cyc;
        bit ok;
        bit stable;
        waitValid(cyc, ok);
        if (!ok) return;
        checkBeat(rank, h, t, o, last);
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                @(posedge clk);
                @(negedge clk);
                if (!out_valid || out_rank != 3'(rank) || out_hund != 4'(h) ||
                    out_tens != 4'(t) || out_ones != 4'(o) || out_last != 1'(last))
                    stable = 1'b0;
            end
            checkOutput($sformatf("rank%0d hold stable", rank), 32'(stable), 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    int exp_h [5] = '{1, 0, 0, 0, 0};
    int exp_t [5] = '{4, 3, 2, 1, 1};
    int exp_o [5] = '{1, 3, 0, 5, 1};

    initial begin
        int cyc;
        int total;
        int done_count;
        bit ok;

        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        hi_scores = '0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset valid", 32'(out_valid), 0);
        checkOutput("reset rank", 32'(out_rank), 0);
        checkOutput("reset digits", 32'({out_hund, out_tens, out_ones}), 0);
        checkOutput("reset last", 32'(out_last), 0);
        checkOutput("reset done", 32'(done), 0);
        reset = 1'b0;

        // Nominal pass with out_ready held high
        out_ready = 1'b1;
        applyStimulus(pack(141, 33, 20, 15, 11));
        checkOutput("busy after capture", 32'(busy), 1);
        total = 0;
        for (int b = 0; b < 5; b++) begin
            waitValid(cyc, ok);
            if (!ok) break;
            total += cyc;
            checkOutput($sformatf("beat%0d latency", b + 1), cyc, 8);
            checkBeat(b + 1, exp_h[b], exp_t[b], exp_o[b], (b == 4) ? 1 : 0);
            @(posedge clk);
            @(negedge clk);
            total += 1;
        end
        checkOutput("E0 to last handshake", total, 45);
        checkOutput("nominal done", 32'(done), 1);
        checkOutput("nominal busy in FIN", 32'(busy), 1);
        checkOutput("nominal valid in FIN", 32'(out_valid), 0);
        @(negedge clk);
        checkOutput("nominal done drop", 32'(done), 0);
        checkOutput("nominal busy drop", 32'(busy), 0);
        out_ready = 1'b0;

        // Backpressure on rank2, table overwrite and ignored re-start mid-pass
        applyStimulus(pack(141, 33, 20, 15, 11));
        takeBeat(1, 1, 4, 1, 0, 0);
        hi_scores = pack(99, 98, 97, 96, 95);
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        takeBeat(2, 0, 3, 3, 0, 20);
        takeBeat(3, 0, 2, 0, 0, 0);
        takeBeat(4, 0, 1, 5, 0, 0);
        takeBeat(5, 0, 1, 1, 1, 0);
        done_count = 0;
        repeat (12) begin
            if (done) done_count++;
            @(negedge clk);
        end
        checkOutput("single done", done_count, 1);
        checkOutput("idle after restart test", 32'(busy), 0);

        // Boundary: max score followed by empty slots
        applyStimulus(pack(255, 0, 0, 0, 0));
        takeBeat(1, 2, 5, 5, 0, 0);
        takeBeat(2, 0, 0, 0, 0, 0);
        takeBeat(3, 0, 0, 0, 0, 0);
        takeBeat(4, 0, 0, 0, 0, 0);
        takeBeat(5, 0, 0, 0, 1, 0);
        checkOutput("boundary done", 32'(done), 1);
        repeat (2) @(negedge clk);

        // Reset during PRESENT of rank3
        applyStimulus(pack(141, 33, 20, 15, 11));
        takeBeat(1, 1, 4, 1, 0, 0);
        takeBeat(2, 0, 3, 3, 0, 0);
        waitValid(cyc, ok);
        checkOutput("rank3 before reset", 32'(out_rank), 3);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid reset valid", 32'(out_valid), 0);
        checkOutput("mid reset busy", 32'(busy), 0);
        checkOutput("mid reset done", 32'(done), 0);
        reset = 1'b0;
        done_count = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) done_count++;
        end
        checkOutput("no done after reset", done_count, 0);
        applyStimulus(pack(141, 33, 20, 15, 11));
        for (int b = 0; b < 5; b++) begin
            takeBeat(b + 1, exp_h[b], exp_t[b], exp_o[b], (b == 4) ? 1 : 0, 0);
        end
        checkOutput("post reset done", 32'(done), 1);
        @(negedge clk);
        checkOutput("post reset idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
